// File: rtl/sram_controller.sv
// 32-bit word load/store controller for a 16-bit asynchronous SRAM.
// Each word is moved as two halfword phases; ready stays low while busy.
module sram_controller #(
  parameter int unsigned ADDR_BASE    = 1024,
  parameter int unsigned PHASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(PHASE_CYCLES - 1);

  state_t      r_state, w_next;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [16:0] r_widx;
  logic [31:0] r_wdata;
  logic        r_wr;
  logic [31:0] r_rdata;

  logic [31:0] w_off;
  logic        w_req, w_act, w_last, w_drv, w_unused;
  logic [15:0] w_hw;

  // Out-of-range addresses simply wrap into the 17-bit word index.
  assign w_off    = address - 32'(ADDR_BASE);
  assign w_unused = ^{w_off[31:19], w_off[1:0]};
  assign w_req    = wr_en | rd_en;
  assign w_act    = (r_state == LO) || (r_state == HI);
  assign w_last   = (r_cnt == LAST_CNT);

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_req) w_next = LO;
      end
      LO: begin
        if (w_last) begin
          w_next    = HI;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      HI: begin
        if (w_last) begin
          w_next    = DONE;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      DONE: begin
        w_next    = IDLE;
        w_cnt_nxt = '0;
      end
      default: begin
        w_next    = IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_widx  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (r_state == IDLE && w_req) begin
        r_widx  <= w_off[18:2];
        r_wdata <= write_data;
        r_wr    <= wr_en;
      end
    end
  end

  // Sample the bus on the last cycle of each read phase, when data has settled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (w_act && !r_wr && w_last) begin
      if (r_state == LO) r_rdata[15:0]  <= SRAM_DQ;
      else               r_rdata[31:16] <= SRAM_DQ;
    end
  end

  assign read_data = r_rdata;
  assign ready     = ~w_req | (r_state == DONE);

  assign SRAM_CE_N = ~w_act;
  assign SRAM_UB_N = ~w_act;
  assign SRAM_LB_N = ~w_act;
  assign SRAM_ADDR = w_act ? {r_widx, (r_state == HI)} : 18'd0;
  // WE_N rises one cycle before the phase ends so address/data hold past it.
  assign SRAM_WE_N = ~(w_act & r_wr & ~w_last);
  assign SRAM_OE_N = ~(w_act & ~r_wr);

  assign w_drv   = w_act & r_wr;
  assign w_hw    = (r_state == HI) ? r_wdata[31:16] : r_wdata[15:0];
  assign SRAM_DQ = w_drv ? w_hw : 16'hzzzz;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: two instances (P=2 and P=4), each
// attached to a simple asynchronous SRAM model.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst, sel, wr, rd;
  logic [31:0] addr, wdata;
  int          n_chk = 0;
  int          n_fail = 0;

  logic        wr1, rd1, wr2, rd2;
  logic [31:0] rdat1, rdat2;
  logic        rdy1, rdy2;
  wire  [15:0] dq1, dq2;
  logic [17:0] a1, a2;
  logic        ub1, lb1, we1, ce1, oe1;
  logic        ub2, lb2, we2, ce2, oe2;

  logic [15:0] mem1 [262144];
  logic [15:0] mem2 [262144];

  logic [17:0] tr_addr [64];
  logic        tr_we   [64];
  logic        tr_oe   [64];

  logic        x_ready, x_we, x_oe;
  logic [17:0] x_addr;
  logic [31:0] x_rdat;

  always #5 clk = ~clk;

  assign wr1 = wr & ~sel;
  assign rd1 = rd & ~sel;
  assign wr2 = wr & sel;
  assign rd2 = rd & sel;

  assign x_ready = sel ? rdy2  : rdy1;
  assign x_we    = sel ? we2   : we1;
  assign x_oe    = sel ? oe2   : oe1;
  assign x_addr  = sel ? a2    : a1;
  assign x_rdat  = sel ? rdat2 : rdat1;

  sram_controller #(.ADDR_BASE(1024), .PHASE_CYCLES(2)) u_p2 (
    .clk(clk), .rst(rst), .wr_en(wr1), .rd_en(rd1), .address(addr),
    .write_data(wdata), .read_data(rdat1), .ready(rdy1), .SRAM_DQ(dq1),
    .SRAM_ADDR(a1), .SRAM_UB_N(ub1), .SRAM_LB_N(lb1), .SRAM_WE_N(we1),
    .SRAM_CE_N(ce1), .SRAM_OE_N(oe1)
  );

  sram_controller #(.ADDR_BASE(1024), .PHASE_CYCLES(4)) u_p4 (
    .clk(clk), .rst(rst), .wr_en(wr2), .rd_en(rd2), .address(addr),
    .write_data(wdata), .read_data(rdat2), .ready(rdy2), .SRAM_DQ(dq2),
    .SRAM_ADDR(a2), .SRAM_UB_N(ub2), .SRAM_LB_N(lb2), .SRAM_WE_N(we2),
    .SRAM_CE_N(ce2), .SRAM_OE_N(oe2)
  );

  // SRAM models: drive on read, capture each clock while WE_N is low.
  assign dq1 = (!ce1 && !oe1 && we1) ? mem1[a1] : 16'hzzzz;
  assign dq2 = (!ce2 && !oe2 && we2) ? mem2[a2] : 16'hzzzz;

  always @(posedge clk) begin
    if (!ce1 && !we1) mem1[a1] <= dq1;
    if (!ce2 && !we2) mem2[a2] <= dq2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Raise a request, trace every cycle until ready, return low-cycle count
  // and read_data seen in the DONE cycle, then drop the request.
  task automatic access(input logic s, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] d,
                        output int low, output logic [31:0] rv);
    sel = s; wr = w; rd = r; addr = a; wdata = d; low = 0; rv = '0;
    for (int c = 0; c < 64; c++) begin
      #1;
      tr_addr[c] = x_addr; tr_we[c] = x_we; tr_oe[c] = x_oe;
      if (x_ready) break;
      low++;
      @(negedge clk);
    end
    rv = x_rdat;
    wr = 1'b0; rd = 1'b0;
    @(negedge clk);
  endtask

  int          low, cnt;
  logic [31:0] rv;

  initial begin
    for (int i = 0; i < 262144; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end
    rst = 1'b0; sel = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_rdata1", rdat1, 32'h0);
    chk("rst_rdata2", rdat2, 32'h0);
    chk("rst_ready", {31'd0, rdy1}, 32'd1);
    chk("rst_strobes", {27'd0, ce1, ub1, lb1, we1, oe1}, 32'h1f);
    chk("rst_addr", {14'd0, a1}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Store then load at base address
    access(1'b0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, low, rv);
    chk("wr_low_cycles", low, 32'd5);
    chk("wr_hw0", {16'd0, mem1[0]}, 32'h0000BEEF);
    chk("wr_hw1", {16'd0, mem1[1]}, 32'h0000DEAD);
    chk("wr_we_first", {31'd0, tr_we[1]}, 32'd0);
    chk("wr_we_last", {31'd0, tr_we[2]}, 32'd1);
    chk("wr_keeps_rdata", rv, 32'h0);
    access(1'b0, 1'b0, 1'b1, 32'd1024, 32'h0, low, rv);
    chk("rd_low_cycles", low, 32'd5);
    chk("rd_data", rv, 32'hDEADBEEF);
    chk("rd_oe", {31'd0, tr_oe[1]}, 32'd0);
    chk("rd_we", {31'd0, tr_we[1]}, 32'd1);

    // Address map and ignored low address bits
    access(1'b0, 1'b1, 1'b0, 32'd1032, 32'h12345678, low, rv);
    chk("map_lo_a", {14'd0, tr_addr[1]}, 32'd4);
    chk("map_lo_b", {14'd0, tr_addr[2]}, 32'd4);
    chk("map_hi", {14'd0, tr_addr[3]}, 32'd5);
    access(1'b0, 1'b0, 1'b1, 32'd1034, 32'h0, low, rv);
    chk("map_rd", rv, 32'h12345678);

    // Write wins over simultaneous read
    access(1'b0, 1'b1, 1'b1, 32'd1040, 32'hA5A55A5A, low, rv);
    cnt = 0;
    for (int c = 0; c <= 5; c++) if (!tr_oe[c]) cnt++;
    chk("both_oe_low", cnt, 32'd0);
    chk("both_low_cycles", low, 32'd5);
    chk("both_rdata_kept", rv, 32'h12345678);
    chk("both_hw", {mem1[9], mem1[8]}, 32'hA5A55A5A);
    access(1'b0, 1'b0, 1'b1, 32'd1040, 32'h0, low, rv);
    chk("both_rd", rv, 32'hA5A55A5A);

    // Address below the base wraps to the top of the word space
    access(1'b0, 1'b1, 1'b0, 32'd1020, 32'hCAFEF00D, low, rv);
    chk("wrap_lo", {14'd0, tr_addr[1]}, 32'h3FFFE);
    chk("wrap_hi", {14'd0, tr_addr[3]}, 32'h3FFFF);
    chk("wrap_mem", {mem1[18'h3FFFF], mem1[18'h3FFFE]}, 32'hCAFEF00D);

    // Reset during the HI phase of a read
    sel = 1'b0; rd = 1'b1; addr = 32'd1024;
    @(negedge clk); @(negedge clk); @(negedge clk);
    #1;
    chk("mid_hi_addr", {14'd0, a1}, 32'd1);
    chk("mid_hi_oe", {31'd0, oe1}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_strobes", {27'd0, ce1, ub1, lb1, we1, oe1}, 32'h1f);
    chk("abort_addr", {14'd0, a1}, 32'd0);
    chk("abort_rdata", rdat1, 32'h0);
    chk("abort_ready_req", {31'd0, rdy1}, 32'd0);
    rd = 1'b0;
    #1;
    chk("abort_ready_idle", {31'd0, rdy1}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    access(1'b0, 1'b0, 1'b1, 32'd1024, 32'h0, low, rv);
    chk("post_rst_low", low, 32'd5);
    chk("post_rst_rd", rv, 32'hDEADBEEF);

    // Longer phases
    access(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0BADF00D, low, rv);
    chk("p4_wr_low", low, 32'd9);
    cnt = 0;
    for (int c = 1; c <= 4; c++) if (!tr_we[c]) cnt++;
    chk("p4_we_lo", cnt, 32'd3);
    cnt = 0;
    for (int c = 5; c <= 8; c++) if (!tr_we[c]) cnt++;
    chk("p4_we_hi", cnt, 32'd3);
    chk("p4_mem", {mem2[3], mem2[2]}, 32'h0BADF00D);
    access(1'b1, 1'b0, 1'b1, 32'd1028, 32'h0, low, rv);
    chk("p4_rd_low", low, 32'd9);
    chk("p4_rd_addr_hi", {14'd0, tr_addr[5]}, 32'd3);
    chk("p4_rd", rv, 32'h0BADF00D);

    // Idle bus
    sel = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_ready", {30'd0, rdy1, rdy2}, 32'd3);
      chk("idle_ce", {30'd0, ce1, ce2}, 32'd3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage controller that serves 32-bit word loads and stores from the pipelined datapath out of the board's 16-bit asynchronous SRAM. Each word access is sequenced as two halfword SRAM phases with a fixed number of wait cycles per phase. While an access is in progress, `ready` is held low so the hazard/freeze logic stalls every pipeline stage.

## Interface
Parameters:
- `ADDR_BASE`, 1024: byte address of SRAM word 0 in the processor data space.
- `PHASE_CYCLES`, 2: cycles per halfword phase. Legal range is 2..15.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  store request from the MEM stage.
- `rd_en`  in  1  load request from the MEM stage.
- `address`  in  32  byte address from the ALU result.
- `write_data`  in  32  store data.
- `read_data`  out  32  loaded word.
- `ready`  out  1  low means freeze the pipeline.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  18  SRAM halfword address.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_WE_N`, `SRAM_CE_N`, `SRAM_OE_N`  out  1 each  active-low SRAM strobes.

## Operation
- Word index `widx` = (`address` − `ADDR_BASE`)[18:2], 17 bits.
  - Subtraction is 32-bit. Out-of-range addresses wrap modulo 2^17.
  - `address[1:0]` is ignored.
- Low halfword is stored at `{widx,0}`; high halfword at `{widx,1}`.
- States: IDLE, LO, HI, DONE.
  - IDLE → LO when `wr_en|rd_en` is high at the clock edge.
    - Latch `widx`, `write_data`, and op = write if `wr_en` is high, else read. Write wins when both requests are high.
  - LO → HI after `PHASE_CYCLES` cycles in LO (internal phase counter).
  - HI → DONE after `PHASE_CYCLES` cycles in HI.
  - DONE → IDLE unconditionally after 1 cycle.
- Request inputs are ignored outside IDLE. `address`, `write_data` and op changes mid-access have no effect.
- `ready` = ~(`wr_en`|`rd_en`) | (state==DONE). Combinational.
- In LO and HI:
  - `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N` = 0.
  - `SRAM_ADDR` = current halfword address.
- Write phase:
  - `SRAM_DQ` driven with the halfword (`wdata[15:0]` in LO, `wdata[31:16]` in HI) for every cycle of the phase.
  - `SRAM_WE_N` = 0 on all phase cycles except the last. This keeps the address stable across the WE_N rising edge.
  - `SRAM_OE_N` = 1.
- Read phase:
  - `SRAM_OE_N` = 0, `SRAM_WE_N` = 1, `SRAM_DQ` = high-Z.
  - On the last cycle of each phase, `SRAM_DQ` is registered into `read_data[15:0]` (LO) or `read_data[31:16]` (HI).
- IDLE and DONE:
  - All strobes = 1, `SRAM_ADDR` = 0, `SRAM_DQ` = high-Z.
- `read_data` holds its value until the next read overwrites it. Writes never alter it.

## Timing
- Request first high in cycle 0, controller in IDLE:
  - Cycles 1..P are LO; cycles P+1..2P are HI; cycle 2P+1 is DONE.
  - `ready` is low in cycles 0..2P and high in cycle 2P+1. With P=2, `ready` returns high in cycle 5.
- `read_data` holds the full word from cycle 2P+1 onward, in time for the MEM/WB register edge at the end of DONE.
- Back-to-back requests: the next request is seen in the IDLE cycle after DONE. There is a minimum of 1 ready-high cycle between accesses.
- No request: `ready` = 1 and state stays IDLE. No SRAM activity.
- Reset:
  - Asserting `rst` low at any time forces IDLE and clears the phase counter.
  - `read_data` = 0, `ready` follows its combinational equation, all strobes = 1, `SRAM_ADDR` = 0, `SRAM_DQ` = high-Z.
  - An aborted write may leave SRAM partially written. This is acceptable.
- After `rst` deasserts, the first possible access starts at the next clock edge.

## Test plan
- Store then load, P=2:
  - Write 0xDEADBEEF at address 1024 → halfword 0 = 0xBEEF, halfword 1 = 0xDEAD. `ready` is low 5 cycles.
  - Read address 1024 → `read_data` = 0xDEADBEEF in cycle 5.
- Address map: store 0x12345678 at 1032 → `SRAM_ADDR` = 4 in LO and 5 in HI. Read at 1034 returns 0x12345678 (bits [1:0] ignored).
- Simultaneous `wr_en` = `rd_en` = 1 with data 0xA5A5_5A5A → write performed, `SRAM_OE_N` stays 1. A subsequent read returns 0xA5A55A5A.
- `PHASE_CYCLES` = 4: read request → `ready` low 9 cycles. `SRAM_WE_N` low 3 of 4 cycles per phase on writes.
- Reset mid-access: assert `rst` = 0 during HI of a read → immediately IDLE, strobes high, `read_data` = 0. After release, a new read completes normally in 2P+1 cycles.
- Idle bus: no requests for 20 cycles → `ready` = 1, `SRAM_CE_N` = 1, `SRAM_DQ` = high-Z throughout.
